// File: rtl/handshake_fifo_inferred.sv
// REQ/ACK FIFO with first-word-fall-through output, built on an inferred
// sync-read RAM. Any DEPTH >= 2. The word path is RAM -> read register
// (in-flight word) -> head register. Count covers all three stages, so the
// total capacity is exactly DEPTH.
module handshake_fifo_inferred #(
  parameter int DEPTH         = 1024,
  parameter int WIDTH         = 32,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter bit PARITY_EN     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       flush,
  input  logic                       InputREQ,
  output logic                       InputACK,
  input  logic [WIDTH-1:0]           InputData,
  output logic                       OutputREQ,
  input  logic                       OutputACK,
  output logic [WIDTH-1:0]           OutputData,
  output logic                       OutputParityErr,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty,
  output logic                       AlmostFull,
  output logic                       AlmostEmpty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = WIDTH + 1;   // data plus stored parity bit

  logic [MW-1:0] mem_q [DEPTH];
  logic [MW-1:0] rdata_q;
  logic [MW-1:0] head_q, head_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rv_q, rv_d;     // read register holds a valid in-flight word
  logic          hv_q, hv_d;     // head register valid

  logic          wr_acc, rd_acc, head_load, rd_issue, ram_avail;
  logic [CW-1:0] pipe_occ;
  logic [MW-1:0] wdata;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign Full        = (cnt_q == CW'(DEPTH));
  assign Empty       = (cnt_q == '0);
  assign AlmostFull  = (int'(cnt_q) >= AFULL_THRESH);
  assign AlmostEmpty = (int'(cnt_q) <= AEMPTY_THRESH);
  assign InputACK    = !Full;
  assign Count       = cnt_q;
  assign OutputREQ   = hv_q;
  assign OutputData  = head_q[WIDTH-1:0];
  // Recomputed every cycle from the head word, so it never latches.
  assign OutputParityErr = PARITY_EN && hv_q && (^head_q);

  assign wdata = {(PARITY_EN ? ^InputData : 1'b0), InputData};

  // Full refuses writes even when a read frees a slot this same edge.
  assign wr_acc    = clk_en && InputREQ && !Full;
  assign rd_acc    = clk_en && hv_q && OutputACK;
  // Words still sitting in RAM = Count minus whatever the two stages hold.
  assign pipe_occ  = CW'(hv_q) + CW'(rv_q);
  assign ram_avail = (cnt_q > pipe_occ);
  assign head_load = clk_en && rv_q && (!hv_q || rd_acc);
  // Issue a read whenever the read register is free or is draining into the
  // head this edge; that keeps one word per cycle under back-to-back reads.
  assign rd_issue  = clk_en && ram_avail && (!rv_q || head_load);

  // RAM write port (contents are never reset; flush leaves them alone)
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem_q[wptr_q] <= wdata;
  end

  // RAM synchronous read port; rv_q says whether the word is meaningful
  always_ff @(posedge clk) begin
    if (rd_issue && !flush) rdata_q <= mem_q[rptr_q];
  end

  // Next-state for pointers, occupancy, stage valids and head word
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    rv_d   = rv_q;
    hv_d   = hv_q;
    head_d = head_q;
    if (clk_en) begin
      if (flush) begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
        rv_d   = 1'b0;
        hv_d   = 1'b0;
        head_d = '0;
      end else begin
        if (wr_acc)   wptr_d = ptr_inc(wptr_q);
        if (rd_issue) rptr_d = ptr_inc(rptr_q);
        if (wr_acc && !rd_acc)      cnt_d = cnt_q + CW'(1);
        else if (!wr_acc && rd_acc) cnt_d = cnt_q - CW'(1);
        rv_d = rd_issue || (rv_q && !head_load);
        hv_d = head_load || (hv_q && !rd_acc);
        if (head_load) head_d = rdata_q;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rv_q   <= 1'b0;
      hv_q   <= 1'b0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rv_q   <= rv_d;
      hv_q   <= hv_d;
      head_q <= head_d;
    end
  end
endmodule

// File: tb/tb_handshake_fifo_inferred.sv
// Directed bench for handshake_fifo_inferred at DEPTH=5.
module tb_handshake_fifo_inferred;
  localparam int DEPTH = 5;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n, clk_en, flush;
  logic             InputREQ, InputACK, OutputREQ, OutputACK, OutputParityErr;
  logic [WIDTH-1:0] InputData, OutputData;
  logic [2:0]       Count;
  logic             Full, Empty, AlmostFull, AlmostEmpty;

  int n_cmp = 0;
  int n_bad = 0;

  handshake_fifo_inferred #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .PARITY_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .InputREQ(InputREQ), .InputACK(InputACK), .InputData(InputData),
    .OutputREQ(OutputREQ), .OutputACK(OutputACK), .OutputData(OutputData),
    .OutputParityErr(OutputParityErr), .Count(Count), .Full(Full), .Empty(Empty),
    .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cnt"},   32'(Count), 32'd0);
    chk({tag, "_req"},   32'(OutputREQ), 32'd0);
    chk({tag, "_data"},  OutputData, 32'd0);
    chk({tag, "_perr"},  32'(OutputParityErr), 32'd0);
    chk({tag, "_full"},  32'(Full), 32'd0);
    chk({tag, "_empty"}, 32'(Empty), 32'd1);
    chk({tag, "_ae"},    32'(AlmostEmpty), 32'd1);
    chk({tag, "_af"},    32'(AlmostFull), 32'd0);
    chk({tag, "_iack"},  32'(InputACK), 32'd1);
  endtask

  task automatic push(input logic [31:0] d);
    InputREQ = 1'b1; InputData = d;
    tick();
    InputREQ = 1'b0;
  endtask

  // Wait (bounded) for a head word, check it, then take it.
  task automatic pop(input string tag, input logic [31:0] exp_d, input logic exp_pe);
    int n = 0;
    while (!OutputREQ && n < 8) begin tick(); n++; end
    chk({tag, "_req"},  32'(OutputREQ), 32'd1);
    chk({tag, "_data"}, OutputData, exp_d);
    chk({tag, "_perr"}, 32'(OutputParityErr), 32'(exp_pe));
    OutputACK = 1'b1;
    tick();
    OutputACK = 1'b0;
  endtask

  initial begin
    logic [31:0] expd;
    logic [32:0] word;
    int          nrd;
    logic        wtake;

    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0;
    InputREQ = 1'b0; InputData = '0; OutputACK = 1'b0;
    #22;
    chk_reset_state("rst");
    rst_n = 1'b1;
    tick();

    // First-word latency: write at edge k, head valid after k+2.
    push(32'hA5A5A5A5);
    chk("lat_cnt_k", 32'(Count), 32'd1);
    chk("lat_req_k", 32'(OutputREQ), 32'd0);
    tick();
    chk("lat_req_k1", 32'(OutputREQ), 32'd0);
    tick();
    chk("lat_req_k2", 32'(OutputREQ), 32'd1);
    chk("lat_data", OutputData, 32'hA5A5A5A5);
    chk("lat_empty", 32'(Empty), 32'd0);
    chk("lat_ae", 32'(AlmostEmpty), 32'd1);
    pop("lat_pop", 32'hA5A5A5A5, 1'b0);
    chk("lat_cnt0", 32'(Count), 32'd0);
    chk("lat_empty1", 32'(Empty), 32'd1);

    // Fill to DEPTH with no reads; the sixth request must be refused.
    for (int i = 1; i <= 5; i++) begin
      push(32'(i));
      chk("fill_cnt", 32'(Count), 32'(i));
    end
    chk("full_flag", 32'(Full), 32'd1);
    chk("full_iack", 32'(InputACK), 32'd0);
    chk("full_af", 32'(AlmostFull), 32'd1);
    push(32'd6);
    chk("full_refuse_cnt", 32'(Count), 32'd5);
    chk("full_head", OutputData, 32'd1);

    // Full with simultaneous read and write: read wins, write refused.
    InputREQ = 1'b1; InputData = 32'd6; OutputACK = 1'b1;
    tick();
    OutputACK = 1'b0;
    chk("rw_cnt", 32'(Count), 32'd4);
    chk("rw_head", OutputData, 32'd2);
    chk("rw_full", 32'(Full), 32'd0);
    chk("rw_af", 32'(AlmostFull), 32'd1);
    tick();
    InputREQ = 1'b0;
    chk("rw_next_write", 32'(Count), 32'd5);
    // Back-to-back drain: 2..6, one per cycle.
    OutputACK = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_req", 32'(OutputREQ), 32'd1);
      chk("drain_data", OutputData, 32'(2 + i));
      tick();
    end
    OutputACK = 1'b0;
    chk("drain_empty", 32'(Empty), 32'd1);
    chk("drain_req0", 32'(OutputREQ), 32'd0);

    // Streaming through pointer wrap: 15 cycles with REQ and ACK high.
    InputREQ = 1'b1; OutputACK = 1'b1; InputData = 32'd100;
    expd = 32'd100; nrd = 0;
    for (int c = 0; c < 3 * DEPTH; c++) begin
      if (OutputREQ) begin
        chk("stream_data", OutputData, expd);
        expd++; nrd++;
      end
      wtake = InputACK;
      tick();
      if (wtake) InputData++;
    end
    InputREQ = 1'b0;
    chk("stream_reads", 32'(nrd), 32'd12);
    chk("stream_cnt", 32'(Count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("stream_tail_req", 32'(OutputREQ), 32'd1);
      chk("stream_tail_data", OutputData, expd);
      expd++;
      tick();
    end
    OutputACK = 1'b0;
    chk("stream_empty", 32'(Empty), 32'd1);

    // Freeze with clk_en=0, then flush with a concurrent write and read.
    push(32'd7); push(32'd8); push(32'd9);
    tick();
    chk("fl_cnt3", 32'(Count), 32'd3);
    chk("fl_head", OutputData, 32'd7);
    clk_en = 1'b0; InputREQ = 1'b1; InputData = 32'd10; OutputACK = 1'b1;
    tick(); tick();
    chk("freeze_cnt", 32'(Count), 32'd3);
    chk("freeze_data", OutputData, 32'd7);
    chk("freeze_req", 32'(OutputREQ), 32'd1);
    clk_en = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; InputREQ = 1'b0; OutputACK = 1'b0;
    chk_reset_state("flush");
    tick(); tick();
    chk("flush_stays_empty", 32'(OutputREQ), 32'd0);

    // Parity: corrupt the stored 0x44 (at RAM address 3 after the flush).
    push(32'h11); push(32'h22); push(32'h33); push(32'h44); push(32'h55);
    word = dut.mem_q[3];
    word[0] = ~word[0];
    dut.mem_q[3] = word;
    pop("par0", 32'h11, 1'b0);
    pop("par1", 32'h22, 1'b0);
    pop("par2", 32'h33, 1'b0);
    pop("par3", 32'h45, 1'b1);
    pop("par4", 32'h55, 1'b0);
    chk("par_empty", 32'(Empty), 32'd1);

    // Asynchronous reset mid-stream.
    push(32'h77); push(32'h88);
    tick(); tick();
    chk("mid_req", 32'(OutputREQ), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cnt", 32'(Count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
